// File: rtl/cam_capture_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cam_capture_ctrl_pkg
// Description : Shared camera definitions: capture sequencer state encoding
//               and the default frame geometry used by the reader.
// Revision    : 1.0 - initial release
// ============================================================================
package cam_capture_ctrl_pkg;

    // Capture sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,   // waiting for a start command
        ST_ARM    = 2'd1,   // waiting for the VSYNC rising edge
        ST_VBLANK = 2'd2,   // waiting for VSYNC to fall
        ST_ACTIVE = 2'd3    // forwarding pixels
    } cap_state_e;

    // Default sensor geometry
    localparam int CAM_WIDTH  = 640;
    localparam int CAM_HEIGHT = 480;

endpackage
`default_nettype wire

// File: rtl/cam_xy_counter.sv
`default_nettype none
// ============================================================================
// Module      : cam_xy_counter
// Description : Pixel/line position tracker for one frame. Wraps x at the
//               line width, saturates y at HEIGHT+1, flags short lines and
//               reports whether the frame so far has exact geometry.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_xy_counter #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic pclk,
    input  logic rst_n,
    input  logic clr_i,        // start of a new frame
    input  logic active_i,     // sequencer is forwarding pixels
    input  logic pix_valid_i,  // reader pixel strobe
    output logic eol_o,        // current pixel is the last of its line
    output logic short_o,      // a line ended before reaching WIDTH pixels
    output logic frame_ok_o    // exactly HEIGHT full lines seen
);

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = $clog2(HEIGHT + 2);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_FULL = YW'(HEIGHT);
    localparam logic [YW-1:0] Y_SAT  = YW'(HEIGHT + 1);

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [YW-1:0] y_inc;
    logic          pv_q;
    logic          short_seen_q;

    // y stops at HEIGHT+1 so an over-long frame can never wrap back to "good"
    assign y_inc      = (y_q == Y_SAT) ? y_q : y_q + YW'(1);
    assign eol_o      = (x_q == X_LAST);
    assign short_o    = active_i && !pix_valid_i && pv_q && (x_q != '0);
    assign frame_ok_o = (y_q == Y_FULL) && (x_q == '0) && !short_seen_q;

    // Position counters and pixel-strobe edge history
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            x_q          <= '0;
            y_q          <= '0;
            pv_q         <= 1'b0;
            short_seen_q <= 1'b0;
        end else begin
            pv_q <= pix_valid_i;
            if (clr_i) begin
                x_q          <= '0;
                y_q          <= '0;
                short_seen_q <= 1'b0;
            end else if (active_i) begin
                if (pix_valid_i) begin
                    if (eol_o) begin
                        x_q <= '0;
                        y_q <= y_inc;
                    end else begin
                        x_q <= x_q + XW'(1);
                    end
                end else if (short_o) begin
                    // A truncated line still counts as a line but spoils the frame
                    x_q          <= '0;
                    y_q          <= y_inc;
                    short_seen_q <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cam_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cam_capture_ctrl
// Description : Frame-level capture sequencer. Starts the reader, aligns to
//               VSYNC, forwards pixels with SOF/EOL markers and reports frame
//               count, geometry errors and downstream overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_capture_ctrl
    import cam_capture_ctrl_pkg::*;
#(
    parameter int WIDTH  = CAM_WIDTH,
    parameter int HEIGHT = CAM_HEIGHT,
    parameter int FCNT_W = 16
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              cmd_start,
    input  logic              cmd_single,
    input  logic              cmd_stop,
    input  logic              cam_vsync,
    input  logic              rd_pixel_valid,
    input  logic [7:0]        rd_pixel,
    output logic              rd_start,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic              out_sof,
    output logic              out_eol,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              err_geom,
    output logic              err_ovf
);

    cap_state_e        state_q;
    logic              vsync_q;
    logic              single_q;
    logic              stop_pend_q;
    logic              sof_pend_q;
    logic              rd_start_q;
    logic              out_valid_q;
    logic [7:0]        out_data_q;
    logic              out_sof_q;
    logic              out_eol_q;
    logic              done_q;
    logic [FCNT_W-1:0] frame_cnt_q;
    logic              err_geom_q;
    logic              err_ovf_q;

    logic vs_rise;
    logic vs_fall;
    logic xy_eol;
    logic xy_short;
    logic xy_frame_ok;

    assign vs_rise = cam_vsync & ~vsync_q;
    assign vs_fall = ~cam_vsync & vsync_q;

    cam_xy_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_xy (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .clr_i       ((state_q == ST_VBLANK) && vs_fall),
        .active_i    (state_q == ST_ACTIVE),
        .pix_valid_i (rd_pixel_valid),
        .eol_o       (xy_eol),
        .short_o     (xy_short),
        .frame_ok_o  (xy_frame_ok)
    );

    // Capture sequencer with registered pixel path and status outputs
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            vsync_q     <= 1'b0;
            single_q    <= 1'b0;
            stop_pend_q <= 1'b0;
            sof_pend_q  <= 1'b0;
            rd_start_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
            err_geom_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            vsync_q     <= cam_vsync;
            rd_start_q  <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;

            // The stream cannot stall, so an unaccepted pixel is simply lost
            if (out_valid_q && !out_ready) begin
                err_ovf_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (cmd_start) begin
                        state_q     <= ST_ARM;
                        rd_start_q  <= 1'b1;
                        single_q    <= cmd_single;
                        // A stop arriving with start turns this into one frame
                        stop_pend_q <= cmd_stop;
                        err_geom_q  <= 1'b0;
                        err_ovf_q   <= 1'b0;
                        frame_cnt_q <= '0;
                    end
                end
                ST_ARM: begin
                    if (cmd_stop) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end else if (vs_rise) begin
                        state_q <= ST_VBLANK;
                    end
                end
                ST_VBLANK: begin
                    if (cmd_stop) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end else if (vs_fall) begin
                        state_q    <= ST_ACTIVE;
                        sof_pend_q <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (cmd_stop) begin
                        stop_pend_q <= 1'b1;
                    end
                    if (rd_pixel_valid) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= rd_pixel;
                        out_sof_q   <= sof_pend_q;
                        out_eol_q   <= xy_eol;
                        sof_pend_q  <= 1'b0;
                    end
                    if (xy_short) begin
                        err_geom_q <= 1'b1;
                    end
                    if (vs_rise) begin
                        if (xy_frame_ok) begin
                            frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
                        end else begin
                            err_geom_q <= 1'b1;
                        end
                        if (single_q || stop_pend_q || cmd_stop) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_VBLANK;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_start  = rd_start_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sof   = out_sof_q;
    assign out_eol   = out_eol_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;
    assign err_geom  = err_geom_q;
    assign err_ovf   = err_ovf_q;

endmodule
`default_nettype wire

// File: doc/cam_capture_ctrl.md
# cam_capture_ctrl

Frame-level sequencer for the camera reader. It issues the reader's start pulse and aligns capture to VSYNC frame boundaries. It forwards the reader's raw 8-bit pixel stream downstream with start-of-frame and end-of-line markers, and supports single-shot or continuous capture with a graceful stop at the next frame boundary. It sits between the reader and the frame-buffer writer, and reports frame count, geometry errors and downstream overflow to the control/status registers.

## Interface
Parameters:
- `WIDTH`, default 640: expected pixels per line.
- `HEIGHT`, default 480: expected lines per frame.
- `FCNT_W`, default 16: width of the frame counter.

Ports:
- `pclk`  in  1: pixel clock; the only clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `cmd_start`  in  1: one-cycle pulse; starts capture. Ignored unless in IDLE.
- `cmd_single`  in  1: sampled with `cmd_start`. 1 = capture one frame; 0 = continuous.
- `cmd_stop`  in  1: one-cycle pulse; requests a stop at the next frame boundary.
- `cam_vsync`  in  1: sensor VSYNC, already synchronous to `pclk`.
- `rd_pixel_valid`  in  1: reader pixel strobe.
- `rd_pixel`  in  8: reader raw pixel.
- `rd_start`  out  1: one-cycle start pulse to the reader.
- `out_valid`  out  1: downstream pixel valid.
- `out_data`  out  8: downstream pixel.
- `out_sof`  out  1: marks the first pixel of a frame.
- `out_eol`  out  1: marks the last pixel of a line.
- `out_ready`  in  1: downstream ready. There is no buffering in this block.
- `busy`  out  1: high whenever the block is not in IDLE.
- `done`  out  1: one-cycle pulse on the return to IDLE.
- `frame_cnt`  out  FCNT_W: number of complete frames forwarded.
- `err_geom`  out  1: sticky; a frame ended with the wrong pixel or line count.
- `err_ovf`  out  1: sticky; a pixel was dropped because `out_ready` was low.

## Operation
- States:
  - IDLE: waiting for a start command.
  - ARM: waiting for the VSYNC rising edge.
  - VBLANK: waiting for VSYNC to fall.
  - ACTIVE: forwarding pixels.
- `vs_rise` = `cam_vsync & !vsync_d1`; `vs_fall` = `!cam_vsync & vsync_d1`. `vsync_d1` is an internal register.
- IDLE → ARM on `cmd_start`:
  - pulse `rd_start`;
  - latch `cmd_single` into `single_q`;
  - clear `stop_pend`, `err_geom`, `err_ovf` and `frame_cnt`.
- ARM → VBLANK on `vs_rise`. Pixels arriving in ARM are discarded, so a partial first frame is never captured.
- VBLANK → ACTIVE on `vs_fall`; clear x and y, set `sof_pend`.
- ACTIVE, for each `rd_pixel_valid` cycle:
  - forward the pixel;
  - `out_sof` = `sof_pend`, then clear `sof_pend`;
  - `out_eol` = (x == WIDTH-1);
  - x increments; on wrap, x returns to 0 and y increments.
- ACTIVE, on a `rd_pixel_valid` falling edge with x != 0 (short line): set `err_geom`, set x to 0, increment y.
- ACTIVE on `vs_rise` (end of frame):
  - if y == HEIGHT and x == 0, increment `frame_cnt` (wraps modulo 2^FCNT_W); otherwise set `err_geom` and leave `frame_cnt` unchanged;
  - if `single_q` or `stop_pend` (including a `cmd_stop` in the same cycle), go to IDLE and pulse `done`; otherwise go to VBLANK.
- `cmd_stop` in ARM or VBLANK goes to IDLE immediately with a `done` pulse. In ACTIVE it sets `stop_pend`. In IDLE it has no effect.
- y saturates at HEIGHT+1 so that an over-long frame still flags `err_geom`.
- `err_ovf` is set when `out_valid && !out_ready`. The pixel is dropped and counting continues.
- A simultaneous `cmd_start` and `cmd_stop` in IDLE: start wins and `stop_pend` is set, so the effect is a single frame.

## Timing
- Reset values: all outputs 0; state IDLE.
- `rd_start` is asserted the cycle after `cmd_start` is sampled.
- Pixel path latency is 1 cycle: `out_valid`, `out_data`, `out_sof` and `out_eol` are registered from the cycle in which `rd_pixel_valid` is sampled.
- `out_valid` is never held waiting for `out_ready`, because the reader stream cannot stall.
- `done`, `frame_cnt` and `err_geom` update the cycle after the `vs_rise` sample.
- `busy` falls in the same cycle that `done` is high.
- Reset asserted mid-frame: outputs clear immediately (asynchronously). After release, the block needs a fresh `cmd_start` and then a full ARM sequence.

## Structure
- Shared camera package holds the state encoding enum, and the default `WIDTH`/`HEIGHT` constants shared with the reader.
- One sub-module: `cam_xy_counter` (x/y counter with wrap and saturation, eol and geometry check).

## Test plan
- Single shot, WIDTH=8, HEIGHT=4, ideal sensor model with the ARM start placed mid-frame. Required: first frame ignored; exactly 32 `out_valid`; one `out_sof`; 4 `out_eol`; `frame_cnt`=1; `done` pulses once; `err_geom`=0.
- Continuous for 3 frames, then `cmd_stop` mid-frame 3. Required: frame 3 completes; `frame_cnt`=3; `done` at frame 3's `vs_rise`; no pixels forwarded afterwards.
- Frame of 3 lines instead of 4, or one line of 7 pixels. Required: `err_geom`=1, `frame_cnt` unchanged, capture continues.
- `out_ready` held low for 1 cycle during ACTIVE. Required: `err_ovf`=1 and sticky; remains set until the next `cmd_start`.
- `cmd_stop` in ARM, and `cmd_start`+`cmd_stop` together in IDLE. Required: immediate IDLE with a `done` pulse; the simultaneous case captures exactly one frame.
- `rst_n` pulsed low mid-ACTIVE. Required: all outputs 0 asynchronously; no `out_valid` until a new start plus VSYNC alignment.
